// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter and the RTC state machines that use it.
//   - arb_state_e : arbiter FSM state encoding
//   - REQ_*       : requester indices (init sequencer, user write path, read sweep)
//   - RTC_ADDR_*  : RTC register addresses used by the read/write/reset machines
//   - idx2oh/lane : index-to-one-hot and 8-bit lane select helpers
package rtc_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StWait = 2'd2
    } arb_state_e;

    localparam int unsigned NumReq = 3;

    localparam logic [1:0] REQ_INIT = 2'd0;
    localparam logic [1:0] REQ_WR   = 2'd1;
    localparam logic [1:0] REQ_RD   = 2'd2;

    localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
    localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
    localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;

    function automatic logic [NumReq-1:0] idx2oh(input logic [1:0] idx);
        logic [NumReq-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Byte lane of requester idx within a packed 3x8 bus.
    function automatic logic [7:0] lane(input logic [23:0] bus, input logic [1:0] idx);
        logic [7:0] v;
        case (idx)
            2'd0:    v = bus[7:0];
            2'd1:    v = bus[15:8];
            2'd2:    v = bus[23:16];
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rtc_arb_pick.sv
// Combinational 3-way priority picker for the RTC bus arbiter.
// Lowest requester index wins, except that requester 2 (read sweep) is forced to win while
// the starvation guard is asserted and it is requesting.
// Ports:
//   req_i    in  3  request vector
//   starve_i in  1  starvation guard for requester 2 has saturated
//   idx_o    out 2  index of the chosen requester (0 when nothing requests)
//   valid_o  out 1  at least one request present
module rtc_arb_pick
    import rtc_bus_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req_i,
    input  logic              starve_i,
    output logic [1:0]        idx_o,
    output logic              valid_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = REQ_INIT;
        if (req_i[REQ_RD] && starve_i) begin
            idx_o = REQ_RD;
        end else if (req_i[REQ_INIT]) begin
            idx_o = REQ_INIT;
        end else if (req_i[REQ_WR]) begin
            idx_o = REQ_WR;
        end else if (req_i[REQ_RD]) begin
            idx_o = REQ_RD;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbiter sharing the single RTC protocol engine between the init sequencer (0), the user
// write path (1) and the permanent read sweep (2). One owner at a time, exactly one engine
// transaction per handshake, fixed priority 0>1>2 with a starvation guard for 2, and an
// optional per-requester lock that keeps ownership across a burst. All outputs registered.
// Ports:
//   clk, Reset_n             clock, asynchronous active-low reset
//   req_i/lock_i/rw_i [3]    per-requester request, burst lock, direction (1=read)
//   addr_i/wdata_i [24]      per-requester address/write data, requester k at [8k+7:8k]
//   gnt_o [3]                one-hot grant
//   ack_o/err_o [3]          one-cycle completion / timeout pulse to the owner
//   rdata_o [8]              read data, updated on read ack and held otherwise
//   eng_start_o/rw/addr/wdata  request to the protocol engine, stable while waiting
//   eng_busy_i/done_i/rdata_i  engine status and read data
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 2048,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] lock_i,
    input  logic [NumReq-1:0] rw_i,
    input  logic [23:0]       addr_i,
    input  logic [23:0]       wdata_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [NumReq-1:0] ack_o,
    output logic [NumReq-1:0] err_o,
    output logic [7:0]        rdata_o,
    output logic              eng_start_o,
    output logic              eng_rw_o,
    output logic [7:0]        eng_addr_o,
    output logic [7:0]        eng_wdata_o,
    input  logic              eng_busy_i,
    input  logic              eng_done_i,
    input  logic [7:0]        eng_rdata_i
);

    localparam int unsigned TimerW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [NumReq-1:0] ack_q, ack_d;
    logic [NumReq-1:0] err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              start_q, start_d;
    logic              eng_rw_q, eng_rw_d;
    logic [7:0]        eng_addr_q, eng_addr_d;
    logic [7:0]        eng_wdata_q, eng_wdata_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [StarveW-1:0] starve_q, starve_d;

    logic       starve_hit;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       timeout_hit;
    logic       txn_end;
    logic       grant_rd;

    assign starve_hit  = (starve_q == StarveW'(STARVE_LIMIT));
    assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));

    rtc_arb_pick u_pick (
        .req_i   (req_i),
        .starve_i(starve_hit),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Main FSM: next state and all registered outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        start_d     = 1'b0;
        eng_rw_d    = eng_rw_q;
        eng_addr_d  = eng_addr_q;
        eng_wdata_d = eng_wdata_q;
        timer_d     = timer_q;

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = idx2oh(pick_idx);
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (!req_i[owner_q]) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end else if (!eng_busy_i) begin
                    eng_rw_d    = rw_i[owner_q];
                    eng_addr_d  = lane(addr_i, owner_q);
                    eng_wdata_d = lane(wdata_i, owner_q);
                    start_d     = 1'b1;
                    timer_d     = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                // Done is checked first so a completion on the timeout cycle still acks.
                if (eng_done_i) begin
                    ack_d = idx2oh(owner_q);
                    if (eng_rw_q) begin
                        rdata_d = eng_rdata_i;
                    end
                    // A dropped request ends the burst even if lock is still high.
                    if (lock_i[owner_q] && req_i[owner_q]) begin
                        state_d = StOwn;
                    end else begin
                        gnt_d   = '0;
                        state_d = StIdle;
                    end
                end else if (timeout_hit) begin
                    err_d   = idx2oh(owner_q);
                    gnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Starvation guard: counts finished 0/1 transactions while the read sweep waits.
    assign txn_end  = (state_q == StWait) && (eng_done_i || timeout_hit);
    assign grant_rd = (state_q == StIdle) && pick_valid && (pick_idx == REQ_RD);

    always_comb begin
        starve_d = starve_q;
        if (!req_i[REQ_RD] || grant_rd) begin
            starve_d = '0;
        end else if (txn_end && (owner_q != REQ_RD) && !starve_hit) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            owner_q     <= REQ_INIT;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            start_q     <= 1'b0;
            eng_rw_q    <= 1'b0;
            eng_addr_q  <= '0;
            eng_wdata_q <= '0;
            timer_q     <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            start_q     <= start_d;
            eng_rw_q    <= eng_rw_d;
            eng_addr_q  <= eng_addr_d;
            eng_wdata_q <= eng_wdata_d;
            timer_q     <= timer_d;
            starve_q    <= starve_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign eng_start_o = start_q;
    assign eng_rw_o    = eng_rw_q;
    assign eng_addr_o  = eng_addr_q;
    assign eng_wdata_o = eng_wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: a behavioural engine answers each start, expected
// engine requests and completions are queued as stimulus is driven and popped as they appear.
module tb_rtc_bus_arbiter;
    import rtc_bus_arbiter_pkg::*;

    localparam int TO = 16;
    localparam int SL = 8;

    logic       clk;
    logic       Reset_n;
    logic [2:0] req_i, lock_i, rw_i;
    logic [23:0] addr_i, wdata_i;
    logic [2:0] gnt_o, ack_o, err_o;
    logic [7:0] rdata_o;
    logic       eng_start_o, eng_rw_o;
    logic [7:0] eng_addr_o, eng_wdata_o;
    logic       eng_busy_i, eng_done_i;
    logic [7:0] eng_rdata_i;

    rtc_bus_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .rw_i       (rw_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .eng_start_o(eng_start_o),
        .eng_rw_o   (eng_rw_o),
        .eng_addr_o (eng_addr_o),
        .eng_wdata_o(eng_wdata_o),
        .eng_busy_i (eng_busy_i),
        .eng_done_i (eng_done_i),
        .eng_rdata_i(eng_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard
    typedef struct packed {
        logic [2:0] gnt;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } st_item_t;

    typedef struct packed {
        logic [2:0] ack;
        logic [2:0] err;
        logic       rw;
        logic [7:0] rdata;
        logic [7:0] lat;
    } dn_item_t;

    st_item_t st_q[$];
    dn_item_t dn_q[$];
    st_item_t s_it;
    dn_item_t d_it;
    int       last_start = 0;
    logic [7:0] rd_hold = 8'h00;

    // Engine model returns addr ^ 8'h64 as read data.
    task automatic exp_txn(input int who, input logic rw, input logic [7:0] addr,
                           input logic [7:0] wdata, input bit to_err, input int lat);
        st_item_t s;
        dn_item_t d;
        s.gnt   = 3'(1 << who);
        s.rw    = rw;
        s.addr  = addr;
        s.wdata = wdata;
        d.ack   = to_err ? 3'b000 : 3'(1 << who);
        d.err   = to_err ? 3'(1 << who) : 3'b000;
        d.rw    = rw;
        d.rdata = addr ^ 8'h64;
        d.lat   = 8'(lat);
        st_q.push_back(s);
        dn_q.push_back(d);
    endtask

    always @(negedge clk) begin
        if (Reset_n) begin
            check_eq("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
            if (eng_start_o) begin
                if (st_q.size() == 0) begin
                    check_eq("start_unexpected", 32'd1, 32'd0);
                end else begin
                    s_it = st_q.pop_front();
                    check_eq("start_gnt", 32'(gnt_o), 32'(s_it.gnt));
                    check_eq("start_rw", 32'(eng_rw_o), 32'(s_it.rw));
                    check_eq("start_addr", 32'(eng_addr_o), 32'(s_it.addr));
                    if (!s_it.rw) check_eq("start_wdata", 32'(eng_wdata_o), 32'(s_it.wdata));
                    last_start = cyc;
                end
            end
            if (ack_o != 3'b000 || err_o != 3'b000) begin
                check_eq("ack_err_excl", 32'((ack_o != 3'b000) && (err_o != 3'b000)), 32'd0);
                if (dn_q.size() == 0) begin
                    check_eq("done_unexpected", 32'({ack_o, err_o}), 32'd0);
                end else begin
                    d_it = dn_q.pop_front();
                    check_eq("done_ack", 32'(ack_o), 32'(d_it.ack));
                    check_eq("done_err", 32'(err_o), 32'(d_it.err));
                    check_eq("done_latency", 32'(cyc - last_start), 32'(d_it.lat));
                    if (d_it.ack != 3'b000 && d_it.rw) rd_hold = d_it.rdata;
                    check_eq("rdata", 32'(rdata_o), 32'(rd_hold));
                end
            end
        end
    end

    // Behavioural protocol engine
    int eng_lat  = 4;
    bit eng_mute = 1'b0;
    initial begin
        int  cnt;
        bit  active;
        cnt = 0;
        active = 1'b0;
        eng_done_i = 1'b0;
        eng_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            eng_done_i = 1'b0;
            if (!Reset_n) begin
                active = 1'b0;
            end else if (active) begin
                if (cnt <= 1) begin
                    eng_done_i  = 1'b1;
                    eng_rdata_i = eng_addr_o ^ 8'h64;
                    active      = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (eng_start_o && !eng_mute) begin
                active = 1'b1;
                cnt    = eng_lat;
            end
        end
    end

    task automatic set_req(input int who, input logic rw, input logic [7:0] addr,
                           input logic [7:0] wdata);
        rw_i[who]            = rw;
        addr_i[8*who +: 8]   = addr;
        wdata_i[8*who +: 8]  = wdata;
    endtask

    task automatic wait_evt(input int who, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (ack_o[who] || err_o[who]) seen = 1'b1;
        end
        if (!seen) check_eq(tag, 32'd0, 32'd1);
    endtask

    initial begin
        Reset_n = 1'b0;
        req_i = '0; lock_i = '0; rw_i = '0;
        addr_i = '0; wdata_i = '0;
        eng_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt_o), 32'd0);
        check_eq("rst_ackerr", 32'({ack_o, err_o}), 32'd0);
        check_eq("rst_eng", 32'({eng_start_o, eng_rw_o, eng_addr_o, eng_wdata_o}), 32'd0);
        Reset_n = 1'b1;
        @(negedge clk);

        // 1) single read by requester 2, latency and ack
        eng_lat = 10;
        set_req(REQ_RD, 1'b1, RTC_ADDR_SEC, 8'h00);
        exp_txn(2, 1'b1, RTC_ADDR_SEC, 8'h00, 1'b0, 11);
        req_i = 3'b100;
        @(negedge clk);
        check_eq("t1_gnt_k1", 32'(gnt_o), 32'b100);
        check_eq("t1_nostart_k1", 32'(eng_start_o), 32'd0);
        @(negedge clk);
        check_eq("t1_start_k2", 32'(eng_start_o), 32'd1);
        wait_evt(2, "t1_wait");
        check_eq("t1_rdata", 32'(rdata_o), 32'h45);
        check_eq("t1_gnt_rel", 32'(gnt_o), 32'd0);
        req_i[2] = 1'b0;
        @(negedge clk);
        check_eq("t1_ack_pulse", 32'(ack_o), 32'd0);

        // 2) simultaneous requests served 0,1,2 with an idle gap
        eng_lat = 3;
        set_req(REQ_INIT, 1'b0, RTC_ADDR_DAY, 8'h55);
        set_req(REQ_WR, 1'b0, RTC_ADDR_MONTH, 8'h66);
        set_req(REQ_RD, 1'b1, RTC_ADDR_YEAR, 8'h00);
        exp_txn(0, 1'b0, RTC_ADDR_DAY, 8'h55, 1'b0, 4);
        exp_txn(1, 1'b0, RTC_ADDR_MONTH, 8'h66, 1'b0, 4);
        exp_txn(2, 1'b1, RTC_ADDR_YEAR, 8'h00, 1'b0, 4);
        req_i = 3'b111;
        wait_evt(0, "t2_wait0");
        req_i[0] = 1'b0;
        check_eq("t2_gap0", 32'(gnt_o), 32'd0);
        @(negedge clk);
        check_eq("t2_gnt1", 32'(gnt_o), 32'b010);
        wait_evt(1, "t2_wait1");
        req_i[1] = 1'b0;
        check_eq("t2_gap1", 32'(gnt_o), 32'd0);
        @(negedge clk);
        check_eq("t2_gnt2", 32'(gnt_o), 32'b100);
        wait_evt(2, "t2_wait2");
        req_i[2] = 1'b0;
        @(negedge clk);

        // 3) locked write burst by requester 1; requester 0 waits for the lock to fall
        eng_lat = 3;
        set_req(REQ_WR, 1'b0, RTC_ADDR_SEC, 8'h10);
        exp_txn(1, 1'b0, RTC_ADDR_SEC, 8'h10, 1'b0, 4);
        exp_txn(1, 1'b0, RTC_ADDR_MIN, 8'h20, 1'b0, 4);
        exp_txn(1, 1'b0, RTC_ADDR_HOUR, 8'h30, 1'b0, 4);
        lock_i[1] = 1'b1;
        req_i[1]  = 1'b1;
        wait_evt(1, "t3_wait_a");
        check_eq("t3_gnt_held_a", 32'(gnt_o), 32'b010);
        set_req(REQ_WR, 1'b0, RTC_ADDR_MIN, 8'h20);
        set_req(REQ_INIT, 1'b1, RTC_ADDR_DAY, 8'h00);
        exp_txn(0, 1'b1, RTC_ADDR_DAY, 8'h00, 1'b0, 4);
        req_i[0] = 1'b1;
        wait_evt(1, "t3_wait_b");
        check_eq("t3_gnt_held_b", 32'(gnt_o), 32'b010);
        set_req(REQ_WR, 1'b0, RTC_ADDR_HOUR, 8'h30);
        lock_i[1] = 1'b0;
        wait_evt(1, "t3_wait_c");
        check_eq("t3_gnt_rel", 32'(gnt_o), 32'd0);
        req_i[1] = 1'b0;
        @(negedge clk);
        check_eq("t3_gnt0", 32'(gnt_o), 32'b001);
        wait_evt(0, "t3_wait0");
        req_i[0] = 1'b0;
        @(negedge clk);

        // 4) starvation guard: 8 alternating 0/1 transactions, then 2 wins
        eng_lat = 2;
        set_req(REQ_RD, 1'b1, RTC_ADDR_YEAR, 8'h00);
        set_req(REQ_INIT, 1'b0, 8'h30, 8'h01);
        set_req(REQ_WR, 1'b0, 8'h31, 8'h02);
        exp_txn(0, 1'b0, 8'h30, 8'h01, 1'b0, 3);
        req_i = 3'b101;
        for (int i = 0; i < SL; i++) begin
            int cur;
            cur = i % 2;
            wait_evt(cur, "t4_wait");
            req_i[cur] = 1'b0;
            if (i < SL - 1) begin
                if (cur == 0) exp_txn(1, 1'b0, 8'h31, 8'h02, 1'b0, 3);
                else          exp_txn(0, 1'b0, 8'h30, 8'h01, 1'b0, 3);
                req_i[1-cur] = 1'b1;
            end else begin
                exp_txn(2, 1'b1, RTC_ADDR_YEAR, 8'h00, 1'b0, 3);
                exp_txn(0, 1'b0, 8'h30, 8'h01, 1'b0, 3);
                req_i[0] = 1'b1;
            end
        end
        @(negedge clk);
        check_eq("t4_starve_gnt2", 32'(gnt_o), 32'b100);
        wait_evt(2, "t4_wait2");
        req_i[2] = 1'b0;
        wait_evt(0, "t4_wait0");
        req_i[0] = 1'b0;
        @(negedge clk);

        // 5) timeout (lock ignored), then done coinciding with timeout
        eng_mute = 1'b1;
        set_req(REQ_WR, 1'b0, 8'h27, 8'h77);
        exp_txn(1, 1'b0, 8'h27, 8'h77, 1'b1, TO);
        lock_i[1] = 1'b1;
        req_i[1]  = 1'b1;
        wait_evt(1, "t5_wait_to");
        check_eq("t5_gnt_rel", 32'(gnt_o), 32'd0);
        req_i[1]  = 1'b0;
        lock_i[1] = 1'b0;
        @(negedge clk);
        check_eq("t5_err_pulse", 32'({ack_o, err_o}), 32'd0);
        eng_mute = 1'b0;
        eng_lat  = TO - 1;
        set_req(REQ_INIT, 1'b1, 8'h28, 8'h00);
        exp_txn(0, 1'b1, 8'h28, 8'h00, 1'b0, TO);
        req_i[0] = 1'b1;
        wait_evt(0, "t5_wait_same");
        req_i[0] = 1'b0;
        @(negedge clk);

        // 6) busy engine stalls the start; reset during WAIT clears everything
        eng_busy_i = 1'b1;
        eng_lat    = 4;
        set_req(REQ_INIT, 1'b1, 8'h29, 8'h00);
        exp_txn(0, 1'b1, 8'h29, 8'h00, 1'b0, 5);
        req_i[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_busy_nostart", 32'({gnt_o, eng_start_o}), 32'b0010);
        end
        eng_busy_i = 1'b0;
        wait_evt(0, "t6_wait_busy");
        req_i[0] = 1'b0;
        @(negedge clk);

        eng_mute = 1'b1;
        set_req(REQ_RD, 1'b1, 8'h2A, 8'h00);
        st_q.push_back('{gnt: 3'b100, rw: 1'b1, addr: 8'h2A, wdata: 8'h00});
        req_i[2] = 1'b1;
        repeat (4) @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        check_eq("t6_rst_gnt", 32'(gnt_o), 32'd0);
        check_eq("t6_rst_rdata", 32'(rdata_o), 32'd0);
        check_eq("t6_rst_eng", 32'({eng_start_o, eng_rw_o, eng_addr_o, eng_wdata_o}), 32'd0);
        check_eq("t6_rst_ackerr", 32'({ack_o, err_o}), 32'd0);
        check_eq("t6_sb_start_seen", 32'(st_q.size()), 32'd0);
        dn_q.delete();
        st_q.delete();
        rd_hold = 8'h00;
        req_i = '0;
        eng_mute = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);

        eng_lat = 5;
        set_req(REQ_WR, 1'b1, RTC_ADDR_SEC, 8'h00);
        exp_txn(1, 1'b1, RTC_ADDR_SEC, 8'h00, 1'b0, 6);
        req_i[1] = 1'b1;
        wait_evt(1, "t6_wait_post");
        req_i[1] = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("sb_empty", 32'(st_q.size() + dn_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
